uart_tx: RTL and testbench

UART transmitter paired with the existing 8-bit receiver and driven by the same shared baud generator strobe (baud_en, one clk-cycle pulse per bit period).
- Accepts bytes on a valid/ready handshake and buffers them in a small sync FIFO.
- Serializes each byte LSB-first as start bit, 8 data bits, optional parity, and 1 or 2 stop bits.
- Sits between the host/command logic and the board TX pin.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 59 +++++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and line constants, common to TX and RX.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

    // Each state names the bit currently driven on (or expected from) the line.
    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a baud-strobed serializer with optional parity
// and one or two stop bits. The tx line is registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        baud_en,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    uart_state_e    state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           stop_cnt_q, stop_cnt_d;
    logic           tx_q, tx_d;
    logic           pop;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_head;

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_valid && tx_ready),
        .wdata (tx_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign tx       = tx_q;
    assign busy     = (state_q != StIdle) || (fifo_count != '0);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        if (baud_en) begin
            case (state_q)
                StIdle: begin
                    tx_d = IDLE_LEVEL;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = StData;
                end
                StData: begin
                    if (bit_cnt_q != LAST_BIT) begin
                        tx_d      = shift_q[bit_cnt_q + 3'd1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (PARITY_EN != 0) begin
                        // Parity from the latched byte; the FIFO head may already differ.
                        tx_d    = (^shift_q) ^ (PARITY_ODD != 0);
                        state_d = StParity;
                    end else begin
                        tx_d       = IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                        state_d    = StStop;
                    end
                end
                StParity: begin
                    tx_d       = IDLE_LEVEL;
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
                StStop: begin
                    if (STOP_BITS == 2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    tx_d    = IDLE_LEVEL;
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= IDLE_LEVEL;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover 8N1, even/odd parity and two stop bits.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_run;
    logic [1:0] baud_div = 2'd0;
    logic       baud_en;
    logic [7:0] tx_data;
    logic [3:0] tx_valid_v;
    logic [3:0] tx_ready_v;
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [2:0] cnt_v [4];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) baud_div <= baud_div + 2'd1;
    assign baud_en = baud_run && (baud_div == 2'd3);

    // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .tx_data(tx_data),
        .tx_valid(tx_valid_v[0]), .tx_ready(tx_ready_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .fifo_count(cnt_v[0]));
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .tx_data(tx_data),
        .tx_valid(tx_valid_v[1]), .tx_ready(tx_ready_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .fifo_count(cnt_v[1]));
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .tx_data(tx_data),
        .tx_valid(tx_valid_v[2]), .tx_ready(tx_ready_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .fifo_count(cnt_v[2]));
    uart_tx #(.FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .baud_en(baud_en), .tx_data(tx_data),
        .tx_valid(tx_valid_v[3]), .tx_ready(tx_ready_v[3]), .tx(tx_v[3]),
        .busy(busy_v[3]), .fifo_count(cnt_v[3]));

    // Called at a negedge; offers one byte across the next posedge.
    task automatic push(input int which, input logic [7:0] data, output logic acc);
        tx_data = data;
        tx_valid_v[which] = 1'b1;
        acc = tx_ready_v[which];
        @(negedge clk);
        tx_valid_v[which] = 1'b0;
    endtask

    // Waits for a start bit, then samples nbits bit periods (bit 0 = start bit).
    task automatic capture(input int which, input int nbits, output logic [63:0] bits,
                           output logic seen);
        bits = '1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (tx_v[which] == 1'b0) seen = 1'b1;
            else @(negedge clk);
        end
        if (seen) begin
            for (int b = 0; b < nbits; b++) begin
                bits[b] = tx_v[which];
                if (b != nbits - 1) repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        baud_run = 1'b0;
        tx_valid_v = 4'h0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if (tx_v !== 4'hF) begin bad++; $display("FAIL reset_tx got=%b want=1111", tx_v); end
        total++;
        if (tx_ready_v !== 4'hF) begin
            bad++; $display("FAIL reset_ready got=%b want=1111", tx_ready_v);
        end
        total++;
        if (busy_v !== 4'h0) begin bad++; $display("FAIL reset_busy got=%b want=0000", busy_v); end
        total++;
        if (cnt_v[0] !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt_v[0]); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_8n1();
        logic acc, seen;
        logic [63:0] bits, exp;
        baud_run = 1'b1;
        push(0, 8'h55, acc);
        capture(0, 11, bits, seen);
        exp = '1;
        exp[9:0] = {1'b1, 8'h55, 1'b0};
        total++;
        if (!seen || bits !== exp) begin
            bad++; $display("FAIL frame_55 got=%h want=%h seen=%b", bits, exp, seen);
        end
        total++;
        if (busy_v[0] !== 1'b0) begin bad++; $display("FAIL busy_after_55 got=%b want=0", busy_v[0]); end
    endtask

    task automatic test_back_to_back();
        logic acc, seen;
        logic [63:0] bits, exp;
        push(0, 8'hA5, acc);
        push(0, 8'h3C, acc);
        capture(0, 21, bits, seen);
        exp = '1;
        exp[9:0]   = {1'b1, 8'hA5, 1'b0};
        exp[19:10] = {1'b1, 8'h3C, 1'b0};
        total++;
        if (!seen || bits !== exp) begin
            bad++; $display("FAIL back_to_back got=%h want=%h seen=%b", bits, exp, seen);
        end
    endtask

    task automatic test_full();
        logic acc, seen;
        logic [63:0] bits, exp;
        logic [7:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        baud_run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(0, vals[k], acc);
            total++;
            if (acc !== (k < 4)) begin
                bad++; $display("FAIL full_accept%0d got=%b want=%b", k, acc, k < 4);
            end
        end
        total++;
        if (cnt_v[0] !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", cnt_v[0]); end
        total++;
        if (tx_ready_v[0] !== 1'b0) begin
            bad++; $display("FAIL full_ready got=%b want=0", tx_ready_v[0]);
        end
        total++;
        if (tx_v[0] !== 1'b1) begin bad++; $display("FAIL full_idle_tx got=%b want=1", tx_v[0]); end
        baud_run = 1'b1;
        capture(0, 41, bits, seen);
        exp = '1;
        for (int k = 0; k < 4; k++) exp[k*10 +: 10] = {1'b1, vals[k], 1'b0};
        total++;
        if (!seen || bits !== exp) begin
            bad++; $display("FAIL full_drain got=%h want=%h seen=%b", bits, exp, seen);
        end
        total++;
        if (busy_v[0] !== 1'b0 || cnt_v[0] !== 3'd0) begin
            bad++; $display("FAIL full_after busy=%b count=%0d want busy=0 count=0",
                            busy_v[0], cnt_v[0]);
        end
    endtask

    task automatic test_parity();
        logic acc, seen;
        logic [63:0] bits, exp;
        push(1, 8'h07, acc);
        capture(1, 12, bits, seen);
        exp = '1;
        exp[10:0] = {1'b1, 1'b1, 8'h07, 1'b0};
        total++;
        if (!seen || bits !== exp) begin
            bad++; $display("FAIL parity_even got=%h want=%h seen=%b", bits, exp, seen);
        end
        push(2, 8'h07, acc);
        capture(2, 12, bits, seen);
        exp = '1;
        exp[10:0] = {1'b1, 1'b0, 8'h07, 1'b0};
        total++;
        if (!seen || bits !== exp) begin
            bad++; $display("FAIL parity_odd got=%h want=%h seen=%b", bits, exp, seen);
        end
    endtask

    task automatic test_two_stop();
        logic acc, seen;
        logic [63:0] bits, exp;
        push(3, 8'hFF, acc);
        push(3, 8'h00, acc);
        capture(3, 23, bits, seen);
        exp = '1;
        exp[10:0]  = {2'b11, 8'hFF, 1'b0};
        exp[21:11] = {2'b11, 8'h00, 1'b0};
        total++;
        if (!seen || bits !== exp) begin
            bad++; $display("FAIL two_stop got=%h want=%h seen=%b", bits, exp, seen);
        end
        total++;
        if (busy_v[3] !== 1'b0) begin bad++; $display("FAIL two_stop_busy got=%b want=0", busy_v[3]); end
    endtask

    task automatic test_reset_mid();
        logic acc, seen;
        logic [63:0] bits;
        int glitches;
        push(0, 8'h81, acc);
        push(0, 8'hAA, acc);
        push(0, 8'hBB, acc);
        capture(0, 5, bits, seen);
        total++;
        if (!seen || bits[4:0] !== 5'b00010 || tx_v[0] !== 1'b0) begin
            bad++; $display("FAIL pre_reset_bits got=%b want=00010 seen=%b", bits[4:0], seen);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (tx_v[0] !== 1'b1) begin bad++; $display("FAIL async_reset_tx got=%b want=1", tx_v[0]); end
        total++;
        if (cnt_v[0] !== 3'd0 || busy_v[0] !== 1'b0) begin
            bad++; $display("FAIL async_reset_state count=%0d busy=%b want count=0 busy=0",
                            cnt_v[0], busy_v[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        glitches = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) glitches++;
        end
        total++;
        if (glitches != 0) begin
            bad++; $display("FAIL residual_frame got=%0d bad cycles want=0", glitches);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_back_to_back();
        test_full();
        test_parity();
        test_two_stop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
